// File: rtl/str_asm_pkg.sv
// Shared definitions for the string assembler: character width and FSM states.
package str_asm_pkg;

    localparam int CHAR_W = 8;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/str_assembler.sv
// String assembler: collects character beats into a right-justified packed
// string (last character in the low byte), then presents it until consumed.
module str_assembler
    import str_asm_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHAR_W-1:0]            in_char,
    input  logic                         in_last,
    input  logic                         in_empty,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHAR_W*MAX_LEN-1:0]    out_str,
    output logic [$clog2(MAX_LEN+1)-1:0] out_len,
    output logic                         out_ovf
);

    localparam int LEN_W = $clog2(MAX_LEN+1);
    localparam int BUF_W = CHAR_W * MAX_LEN;

    state_t             state_q;
    state_t             state_d;
    logic [BUF_W-1:0]   buf_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               ovf_q;

    logic               accept;
    logic               real_char;
    logic               full;
    logic               consume;

    // A beat carries a real character only when it is not marked empty and is
    // not NUL; NUL bytes vanish exactly as in SV string assignment.
    assign accept    = in_valid && in_ready;
    assign real_char = accept && !in_empty && (in_char != '0);
    assign full      = (cnt_q == LEN_W'(MAX_LEN));
    assign consume   = out_valid && out_ready;

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign out_str   = buf_q;
    assign out_len   = cnt_q;
    assign out_ovf   = ovf_q;

    // State register; reset abandons any partial or held string.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the last accepted beat closes the string, consumption reopens.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (accept && in_last) state_d = HOLD;
            HOLD:    if (out_ready)         state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Shift buffer, count and overflow flag; characters beyond MAX_LEN are
    // dropped so the first MAX_LEN survive, and the flag records the loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (consume) begin
            buf_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (real_char) begin
            if (full) begin
                ovf_q <= 1'b1;
            end else begin
                buf_q <= BUF_W'({buf_q, in_char});
                cnt_q <= cnt_q + LEN_W'(1);
            end
        end
    end

endmodule
